// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, branch/jump flushes, event counters.
// Stall/flush outputs are combinational in the ID cycle; a load feeding a branch adds one registered STALL cycle.
module hazard_ctrl (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_UseRt,
  input  logic        id_Branch,
  input  logic        id_Jump,
  input  logic        id_Equal,
  input  logic        ex_MemRead,
  input  logic        ex_RegWrite,
  input  logic [4:0]  ex_WriteReg,
  input  logic        mem_MemRead,
  input  logic [4:0]  mem_WriteReg,
  output logic        hazard,
  output logic        BranchBubble,
  output logic        id_ex_flush,
  output logic        Branch_ok,
  output logic        if_flush,
  input  logic        cnt_clr,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;
  localparam logic       TYPE_LOAD = 1'b0;
  localparam logic       TYPE_BR   = 1'b1;

  logic [0:0] state;
  logic       remaining;
  logic       saved_type;

  logic       rt_read;
  logic       match_ex;
  logic       match_mem;
  logic [1:0] need;
  logic       in_stall;
  logic       stall_event;

  // Register 0 is hard-wired zero, so it can never carry a dependency.
  always_comb begin
    rt_read   = id_Branch | id_UseRt;
    match_ex  = (ex_WriteReg != 5'd0) &&
                ((ex_WriteReg == id_rs) || (rt_read && (ex_WriteReg == id_rt)));
    match_mem = (mem_WriteReg != 5'd0) &&
                ((mem_WriteReg == id_rs) || (rt_read && (mem_WriteReg == id_rt)));
    need = 2'd0;
    if (id_Branch && ex_MemRead && match_ex) begin
      need = 2'd2;
    end else if ((id_Branch && ex_RegWrite && !ex_MemRead && match_ex) ||
                 (id_Branch && mem_MemRead && match_mem) ||
                 (!id_Branch && ex_MemRead && match_ex)) begin
      need = 2'd1;
    end
  end

  assign in_stall = (state == STALL) && remaining;

  // Outputs are held low while reset is asserted, independent of the pipeline inputs.
  always_comb begin
    hazard       = 1'b0;
    BranchBubble = 1'b0;
    id_ex_flush  = 1'b0;
    Branch_ok    = 1'b0;
    if_flush     = 1'b0;
    if (Rst_n) begin
      if (in_stall) begin
        hazard       = (saved_type == TYPE_LOAD);
        BranchBubble = (saved_type == TYPE_BR);
        id_ex_flush  = 1'b1;
      end else if (need != 2'd0) begin
        hazard       = !id_Branch;
        BranchBubble = id_Branch;
        id_ex_flush  = 1'b1;
      end else begin
        Branch_ok = id_Branch && id_Equal;
        if_flush  = (id_Branch && id_Equal) || id_Jump;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= RUN;
      remaining  <= 1'b0;
      saved_type <= TYPE_LOAD;
    end else if (in_stall) begin
      state     <= RUN;
      remaining <= 1'b0;
    end else if (need == 2'd2) begin
      state      <= STALL;
      remaining  <= 1'b1;
      saved_type <= TYPE_BR;
    end else begin
      state     <= RUN;
      remaining <= 1'b0;
    end
  end

  assign stall_event = hazard | BranchBubble;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else if (cnt_clr) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (stall_event && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (if_flush && (flush_count != 16'hFFFF))     flush_count  <= flush_count + 16'd1;
    end
  end

endmodule
